// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// reset PC default, word size and the bubble instruction.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction-fetch controller.
// Optional misaligned-PC detection is enabled with `define PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] NextPC,
    input  logic        Redirect,
    input  logic        Stall,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] InstrOut,
    output logic        InstrValid,
    output logic        AddrErr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_tgt_q, redir_tgt_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
`ifdef PC_ALIGN_CHECK_EN
    logic         addr_err_q, addr_err_d;
`endif

    // Every PC write funnels through load_en/load_val so the alignment
    // check sees redirect targets and sequential addresses alike.
    logic         load_en;
    logic [31:0]  load_val;

    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        hold_buf_d   = hold_buf_q;
        instr_d      = instr_q;
        valid_d      = 1'b0;
        load_en      = 1'b0;
        load_val     = pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (Redirect && ImemReady) begin
                    load_en      = 1'b1;
                    load_val     = NextPC;
                    redir_pend_d = 1'b0;
                end else if (Redirect) begin
                    redir_tgt_d  = NextPC;
                    redir_pend_d = 1'b1;
                end else if (ImemReady && redir_pend_q) begin
                    load_en      = 1'b1;
                    load_val     = redir_tgt_q;
                    redir_pend_d = 1'b0;
                end else if (ImemReady && Stall) begin
                    hold_buf_d = ImemData;
                    state_d    = S_HOLD;
                end else if (ImemReady) begin
                    instr_d  = ImemData;
                    valid_d  = 1'b1;
                    load_en  = 1'b1;
                    load_val = NextPC;
                end
            end

            S_HOLD: begin
                if (Redirect) begin
                    load_en  = 1'b1;
                    load_val = NextPC;
                    state_d  = S_REQ;
                end else if (!Stall) begin
                    instr_d  = hold_buf_q;
                    valid_d  = 1'b1;
                    load_en  = 1'b1;
                    load_val = NextPC;
                    state_d  = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        if (load_en) begin
            pc_d = {load_val[31:2], 2'b00};
            if (load_val[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            hold_buf_q   <= '0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            hold_buf_q   <= hold_buf_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign AddrErr = addr_err_q;
`else
    assign AddrErr = 1'b0;
`endif

    // Request is decoded from registered state so reset drops it at once.
    assign ImemReq    = (state_q == S_REQ);
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + WORD_BYTES;
    assign InstrOut   = instr_q;
    assign InstrValid = valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; expected values hand-derived.
module tb_pc_fetch_ctrl;

    logic        Clk;
    logic        Reset;
    logic [31:0] NextPC;
    logic        Redirect;
    logic        Stall;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] InstrOut;
    logic        InstrValid;
    logic        AddrErr;

    logic [31:0] tgt;
    logic        force_en;
    logic [31:0] force_data;

    int n_assert;
    int n_fail;

    // Next-PC mux and a memory that returns a tag derived from the address
    assign NextPC   = Redirect ? tgt : PCPlus4;
    assign ImemData = force_en ? force_data : (32'hC0DE_0000 | ImemAddr);

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .NextPC    (NextPC),
        .Redirect  (Redirect),
        .Stall     (Stall),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemReady (ImemReady),
        .ImemData  (ImemData),
        .PC        (PC),
        .PCPlus4   (PCPlus4),
        .InstrOut  (InstrOut),
        .InstrValid(InstrValid),
        .AddrErr   (AddrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] exp_align_pc;
    logic        exp_err;

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        Reset      = 1'b0;
        Redirect   = 1'b0;
        Stall      = 1'b0;
        ImemReady  = 1'b0;
        tgt        = 32'h0;
        force_en   = 1'b0;
        force_data = 32'h0;
`ifdef PC_ALIGN_CHECK_EN
        exp_align_pc = 32'h0000_0100;
        exp_err      = 1'b1;
`else
        exp_align_pc = 32'h0000_0102;
        exp_err      = 1'b0;
`endif

        #1;
        chk32("rst_pc", PC, 32'h0);
        chk1 ("rst_req", ImemReq, 1'b0);
        chk32("rst_addr", ImemAddr, 32'h0);
        chk32("rst_instr", InstrOut, 32'h0);
        chk1 ("rst_valid", InstrValid, 1'b0);
        chk1 ("rst_err", AddrErr, 1'b0);
        chk32("rst_pcp4", PCPlus4, 32'h4);

        // Zero-wait streaming
        #20;
        Reset     = 1'b1;
        ImemReady = 1'b1;
        tick;
        chk1 ("first_req", ImemReq, 1'b1);
        chk32("first_addr", ImemAddr, 32'h0);
        chk1 ("first_valid", InstrValid, 1'b0);
        tick;
        chk32("seq_addr4", ImemAddr, 32'h4);
        chk1 ("seq_valid0", InstrValid, 1'b1);
        chk32("seq_instr0", InstrOut, 32'hC0DE_0000);
        tick;
        chk32("seq_addr8", ImemAddr, 32'h8);
        chk32("seq_instr4", InstrOut, 32'hC0DE_0004);
        tick;
        chk32("seq_addrC", ImemAddr, 32'hC);
        tick;
        chk32("seq_addr10", ImemAddr, 32'h10);
        chk32("seq_instrC", InstrOut, 32'hC0DE_000C);

        // Three wait cycles at 0x10
        ImemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk32("wait_addr", ImemAddr, 32'h10);
            chk1 ("wait_req", ImemReq, 1'b1);
            chk1 ("wait_valid", InstrValid, 1'b0);
        end
        ImemReady = 1'b1;
        tick;
        chk1 ("wait_done_valid", InstrValid, 1'b1);
        chk32("wait_done_instr", InstrOut, 32'hC0DE_0010);
        chk32("wait_done_addr", ImemAddr, 32'h14);
        ImemReady = 1'b0;
        tick;
        chk1 ("single_pulse", InstrValid, 1'b0);
        chk32("single_instr_hold", InstrOut, 32'hC0DE_0010);
        chk32("single_addr", ImemAddr, 32'h14);

        // Redirect to 0x40 while 0x20 is outstanding
        ImemReady = 1'b1;
        tick;
        tick;
        tick;
        chk32("pre_redir_addr", ImemAddr, 32'h20);
        chk32("pre_redir_instr", InstrOut, 32'hC0DE_001C);
        ImemReady = 1'b0;
        Redirect  = 1'b1;
        tgt       = 32'h40;
        tick;
        Redirect = 1'b0;
        chk32("redir_pend_addr", ImemAddr, 32'h20);
        chk1 ("redir_pend_valid", InstrValid, 1'b0);
        tick;
        chk32("redir_pend_addr2", ImemAddr, 32'h20);
        ImemReady = 1'b1;
        tick;
        chk1 ("redir_discard_valid", InstrValid, 1'b0);
        chk32("redir_new_addr", ImemAddr, 32'h40);
        chk32("redir_instr_hold", InstrOut, 32'hC0DE_001C);
        tick;
        chk1 ("redir_fetch_valid", InstrValid, 1'b1);
        chk32("redir_fetch_instr", InstrOut, 32'hC0DE_0040);
        chk32("redir_fetch_pc", PC, 32'h44);

        // Word returns during a four-cycle stall
        Stall      = 1'b1;
        force_en   = 1'b1;
        force_data = 32'hDEAD_BEEF;
        tick;
        chk1 ("hold_req", ImemReq, 1'b0);
        chk1 ("hold_valid", InstrValid, 1'b0);
        chk32("hold_pc", PC, 32'h44);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk1 ("hold_req_n", ImemReq, 1'b0);
            chk1 ("hold_valid_n", InstrValid, 1'b0);
            chk32("hold_pc_n", PC, 32'h44);
        end
        Stall     = 1'b0;
        force_en  = 1'b0;
        ImemReady = 1'b0;
        tick;
        chk32("unhold_instr", InstrOut, 32'hDEAD_BEEF);
        chk1 ("unhold_valid", InstrValid, 1'b1);
        chk32("unhold_pc", PC, 32'h48);
        chk1 ("unhold_req", ImemReq, 1'b1);
        tick;
        chk1 ("unhold_pulse", InstrValid, 1'b0);
        chk32("unhold_instr_hold", InstrOut, 32'hDEAD_BEEF);
        chk32("unhold_addr", ImemAddr, 32'h48);

        // Wrap at the top of the address space
        Redirect  = 1'b1;
        tgt       = 32'hFFFF_FFF8;
        ImemReady = 1'b1;
        tick;
        Redirect = 1'b0;
        chk32("wrap_pc0", PC, 32'hFFFF_FFF8);
        chk1 ("wrap_discard", InstrValid, 1'b0);
        tick;
        chk32("wrap_pc1", PC, 32'hFFFF_FFFC);
        chk32("wrap_pcp4", PCPlus4, 32'h0);
        chk32("wrap_instr1", InstrOut, 32'hFFFF_FFF8);
        tick;
        chk32("wrap_addr", ImemAddr, 32'h0);
        chk32("wrap_instr2", InstrOut, 32'hFFFF_FFFC);
        chk1 ("wrap_valid", InstrValid, 1'b1);

        // Misaligned redirect target
        Redirect = 1'b1;
        tgt      = 32'h0000_0102;
        tick;
        Redirect = 1'b0;
        chk32("align_pc", PC, exp_align_pc);
        chk1 ("align_err", AddrErr, exp_err);
        chk1 ("align_valid", InstrValid, 1'b0);

        // Redirect out of the hold state drops the buffered word
        Stall = 1'b1;
        tick;
        chk1 ("hold2_req", ImemReq, 1'b0);
        Redirect = 1'b1;
        tgt      = 32'h0000_0200;
        tick;
        Redirect  = 1'b0;
        Stall     = 1'b0;
        ImemReady = 1'b0;
        chk32("hold_redir_pc", PC, 32'h200);
        chk1 ("hold_redir_req", ImemReq, 1'b1);
        chk1 ("hold_redir_valid", InstrValid, 1'b0);
        chk1 ("err_sticky", AddrErr, exp_err);

        // Asynchronous reset mid-fetch
        #4;
        Reset = 1'b0;
        #1;
        chk1 ("arst_req", ImemReq, 1'b0);
        chk32("arst_pc", PC, 32'h0);
        chk32("arst_addr", ImemAddr, 32'h0);
        chk1 ("arst_valid", InstrValid, 1'b0);
        chk32("arst_instr", InstrOut, 32'h0);
        chk1 ("arst_err", AddrErr, 1'b0);
        ImemReady = 1'b1;
        #5;
        chk1 ("arst_req_held", ImemReq, 1'b0);
        chk1 ("arst_late_ready", InstrValid, 1'b0);
        #5;
        Reset     = 1'b1;
        ImemReady = 1'b0;
        tick;
        chk1 ("rerun_req", ImemReq, 1'b1);
        chk32("rerun_addr", ImemAddr, 32'h0);
        chk1 ("rerun_valid", InstrValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
